// File: rtl/rf_writeback.sv
// rf_writeback: in-order write-back queue feeding the register file's single
// write port, with forwarding and a pending-write mask for the read side.
module rf_writeback #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic            wb_hold,
    output logic            WrEn_RF,
    output logic [4:0]      WAddr_RF,
    output logic [XLEN-1:0] WD_RF,
    input  logic [4:0]      RAddr1_RF,
    input  logic [4:0]      RAddr2_RF,
    output logic            fwd1_hit,
    output logic            fwd2_hit,
    output logic [XLEN-1:0] fwd1_data,
    output logic [XLEN-1:0] fwd2_data,
    output logic [31:0]     pending,
    output logic            empty,
    output logic            full
);

    localparam int AW = $clog2(DEPTH);

    logic [4:0]      rd_q   [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic            wren_q;
    logic [4:0]      waddr_q;
    logic [XLEN-1:0] wd_q;

    logic [4:0]      push_rd;
    logic [XLEN-1:0] push_data;
    logic            push, pop;

    assign full      = (cnt_q == (AW+1)'(DEPTH));
    assign empty     = (cnt_q == '0);
    assign lsu_ready = !full;
    assign alu_ready = !full && !lsu_valid;
    assign pop       = !wb_hold && !empty;

    assign WrEn_RF  = wren_q;
    assign WAddr_RF = waddr_q;
    assign WD_RF    = wd_q;

    // Select the pushing source (LSU wins); x0 handshakes complete but enqueue nothing.
    always_comb begin
        push_rd   = alu_rd;
        push_data = alu_data;
        if (lsu_valid) begin
            push_rd   = lsu_rd;
            push_data = lsu_data;
        end
        push = !full && (lsu_valid || alu_valid) && (push_rd != 5'd0);
    end

    // Next pointer and occupancy values; simultaneous push and pop keep the count.
    always_comb begin
        wptr_d = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d = pop  ? rptr_q + AW'(1) : rptr_q;
        cnt_d  = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state and output stage; reset discards everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            wren_q  <= 1'b0;
            waddr_q <= '0;
            wd_q    <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            wren_q <= pop;
            if (pop) begin
                waddr_q <= rd_q[rptr_q];
                wd_q    <= data_q[rptr_q];
            end
        end
    end

    // Queue storage; contents are only meaningful under the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[wptr_q]   <= push_rd;
            data_q[wptr_q] <= push_data;
        end
    end

    logic [AW-1:0] idx;

    // Scan oldest to youngest so later matches override: output stage, head, ..., tail.
    always_comb begin
        pending   = '0;
        fwd1_hit  = 1'b0;
        fwd2_hit  = 1'b0;
        fwd1_data = '0;
        fwd2_data = '0;
        idx       = '0;
        if (wren_q) begin
            pending[waddr_q] = 1'b1;
            if (waddr_q == RAddr1_RF) begin
                fwd1_hit  = 1'b1;
                fwd1_data = wd_q;
            end
            if (waddr_q == RAddr2_RF) begin
                fwd2_hit  = 1'b1;
                fwd2_data = wd_q;
            end
        end
        for (int k = 0; k < DEPTH; k++) begin
            idx = rptr_q + AW'(k);
            if ((AW+1)'(k) < cnt_q) begin
                pending[rd_q[idx]] = 1'b1;
                if (rd_q[idx] == RAddr1_RF) begin
                    fwd1_hit  = 1'b1;
                    fwd1_data = data_q[idx];
                end
                if (rd_q[idx] == RAddr2_RF) begin
                    fwd2_hit  = 1'b1;
                    fwd2_data = data_q[idx];
                end
            end
        end
        pending[0] = 1'b0;
        if (RAddr1_RF == 5'd0) begin
            fwd1_hit  = 1'b0;
            fwd1_data = '0;
        end
        if (RAddr2_RF == 5'd0) begin
            fwd2_hit  = 1'b0;
            fwd2_data = '0;
        end
    end

endmodule

// File: tb/tb_rf_writeback.sv
// Directed testbench for rf_writeback with hand-computed expectations.
module tb_rf_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready, lsu_valid, lsu_ready, wb_hold;
    logic [4:0]  alu_rd, lsu_rd, WAddr_RF, RAddr1_RF, RAddr2_RF;
    logic [31:0] alu_data, lsu_data, WD_RF, fwd1_data, fwd2_data, pending;
    logic        WrEn_RF, fwd1_hit, fwd2_hit, empty, full;

    int checks = 0;
    int errors = 0;

    rf_writeback #(.DEPTH(4), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .wb_hold(wb_hold),
        .WrEn_RF(WrEn_RF), .WAddr_RF(WAddr_RF), .WD_RF(WD_RF),
        .RAddr1_RF(RAddr1_RF), .RAddr2_RF(RAddr2_RF),
        .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
        .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
        .pending(pending), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_req(input logic v, input logic [4:0] rd, input logic [31:0] d);
        alu_valid = v;
        alu_rd    = rd;
        alu_data  = d;
    endtask

    task automatic expect_wr(input string tag, input logic en, input logic [4:0] a, input logic [31:0] d);
        check({tag, ".wren"}, WrEn_RF, en);
        if (en) begin
            check({tag, ".waddr"}, WAddr_RF, a);
            check({tag, ".wd"}, WD_RF, d);
        end
    endtask

    initial begin
        rst = 1'b1;
        alu_req(1'b0, 5'd0, 32'd0);
        lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'd0;
        wb_hold = 1'b0; RAddr1_RF = 5'd0; RAddr2_RF = 5'd0;
        step(); step();
        rst = 1'b0;
        #1;
        check("rst.empty", empty, 1'b1);
        check("rst.full", full, 1'b0);
        check("rst.pending", pending, 32'd0);
        check("rst.wren", WrEn_RF, 1'b0);
        check("rst.waddr", WAddr_RF, 5'd0);
        check("rst.wd", WD_RF, 32'd0);
        check("rst.lsu_ready", lsu_ready, 1'b1);
        check("rst.alu_ready", alu_ready, 1'b1);

        // Single write
        alu_req(1'b1, 5'd5, 32'hDEADBEEF);
        #1 check("single.alu_ready", alu_ready, 1'b1);
        step();
        alu_req(1'b0, 5'd0, 32'd0);
        check("single.pend1", pending, 32'h20);
        expect_wr("single.e1", 1'b0, 5'd0, 32'd0);
        step();
        check("single.pend2", pending, 32'h20);
        expect_wr("single.e2", 1'b1, 5'd5, 32'hDEADBEEF);
        step();
        check("single.pend3", pending, 32'd0);
        expect_wr("single.e3", 1'b0, 5'd0, 32'd0);

        // Collision: LSU first, ALU next
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h33;
        alu_req(1'b1, 5'd4, 32'h44);
        #1;
        check("coll.alu_ready", alu_ready, 1'b0);
        check("coll.lsu_ready", lsu_ready, 1'b1);
        step();
        lsu_valid = 1'b0;
        #1 check("coll.alu_ready2", alu_ready, 1'b1);
        step();
        alu_req(1'b0, 5'd0, 32'd0);
        expect_wr("coll.w1", 1'b1, 5'd3, 32'h33);
        step();
        expect_wr("coll.w2", 1'b1, 5'd4, 32'h44);
        step();
        expect_wr("coll.w3", 1'b0, 5'd0, 32'd0);

        // Fill / drain twice (pointer wrap)
        for (int r = 0; r < 2; r++) begin
            wb_hold = 1'b1;
            for (int i = 1; i <= 4; i++) begin
                alu_req(1'b1, 5'(i), 32'h100 * (r + 1) + 32'(i));
                step();
            end
            alu_req(1'b1, 5'd9, 32'h99 + 32'(r));
            #1;
            check("fill.full", full, 1'b1);
            check("fill.lsu_ready", lsu_ready, 1'b0);
            check("fill.alu_ready", alu_ready, 1'b0);
            check("fill.pending", pending, 32'h1E);
            step();
            check("fill.stall_full", full, 1'b1);
            expect_wr("fill.stall", 1'b0, 5'd0, 32'd0);
            wb_hold = 1'b0;
            step();
            expect_wr("drain.x1", 1'b1, 5'd1, 32'h100 * (r + 1) + 32'd1);
            check("drain.alu_ready", alu_ready, 1'b1);
            step();
            alu_req(1'b0, 5'd0, 32'd0);
            expect_wr("drain.x2", 1'b1, 5'd2, 32'h100 * (r + 1) + 32'd2);
            check("drain.pend", pending, 32'h21C);
            step();
            expect_wr("drain.x3", 1'b1, 5'd3, 32'h100 * (r + 1) + 32'd3);
            step();
            expect_wr("drain.x4", 1'b1, 5'd4, 32'h100 * (r + 1) + 32'd4);
            step();
            expect_wr("drain.x9", 1'b1, 5'd9, 32'h99 + 32'(r));
            step();
            expect_wr("drain.idle", 1'b0, 5'd0, 32'd0);
            check("drain.empty", empty, 1'b1);
        end

        // x0 discard
        alu_req(1'b1, 5'd0, 32'hFFFFFFFF);
        #1 check("x0.alu_ready", alu_ready, 1'b1);
        step();
        alu_req(1'b0, 5'd0, 32'd0);
        check("x0.empty", empty, 1'b1);
        check("x0.pending", pending, 32'd0);
        step();
        expect_wr("x0.wren", 1'b0, 5'd0, 32'd0);

        // Forwarding: youngest of two x7 writes
        wb_hold = 1'b1;
        alu_req(1'b1, 5'd7, 32'h11);
        step();
        alu_req(1'b1, 5'd7, 32'h22);
        step();
        alu_req(1'b0, 5'd0, 32'd0);
        RAddr1_RF = 5'd7; RAddr2_RF = 5'd0;
        #1;
        check("fwd.hit1", fwd1_hit, 1'b1);
        check("fwd.data1", fwd1_data, 32'h22);
        check("fwd.hit2", fwd2_hit, 1'b0);
        check("fwd.data2", fwd2_data, 32'd0);
        check("fwd.pending", pending, 32'h80);
        wb_hold = 1'b0;
        step();
        expect_wr("fwd.w1", 1'b1, 5'd7, 32'h11);
        check("fwd.data1b", fwd1_data, 32'h22);
        step();
        expect_wr("fwd.w2", 1'b1, 5'd7, 32'h22);
        check("fwd.hit1c", fwd1_hit, 1'b1);
        check("fwd.data1c", fwd1_data, 32'h22);
        step();
        check("fwd.hit1d", fwd1_hit, 1'b0);
        check("fwd.data1d", fwd1_data, 32'd0);
        check("fwd.pend_clr", pending, 32'd0);
        RAddr1_RF = 5'd0;

        // Asynchronous reset mid-cycle with 3 queued and a write in the output stage
        wb_hold = 1'b1;
        for (int i = 10; i <= 13; i++) begin
            alu_req(1'b1, 5'(i), 32'(i));
            step();
        end
        alu_req(1'b0, 5'd0, 32'd0);
        wb_hold = 1'b0;
        step();
        expect_wr("arst.pre", 1'b1, 5'd10, 32'd10);
        check("arst.pre_pend", pending, 32'h3C00);
        #2 rst = 1'b1;
        #1;
        check("arst.wren", WrEn_RF, 1'b0);
        check("arst.waddr", WAddr_RF, 5'd0);
        check("arst.pending", pending, 32'd0);
        check("arst.empty", empty, 1'b1);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("arst.no_write", WrEn_RF, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
